// File: rtl/axi_burst_stb.sv
// AXI4 burst store engine: streams a contiguous block of UR-file beats to memory
// as INCR bursts capped by MAX_BEATS and 4 KB pages, one request at a time.
module axi_burst_stb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int UR_AW     = 12,
  parameter int LEN_W     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // store request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [UR_AW-1:0]      req_ur_base,
  input  logic [LEN_W-1:0]      req_beats,
  input  logic [DATA_W/8-1:0]   req_last_strb,
  // AXI write address
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  // AXI write data
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  // AXI write response
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  // UR file read port
  output logic                  ur_re,
  output logic [UR_AW-1:0]      ur_addr,
  input  logic [DATA_W-1:0]     ur_rdata,
  // status
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = ((LEN_W > 13) ? LEN_W : 13) + 1;

  typedef enum logic [2:0] {IDLE, AW, W, B, FIN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cur_addr;
  logic [UR_AW-1:0]    ur_ptr;
  logic [LEN_W-1:0]    remaining;
  logic [BYTES-1:0]    last_strb;
  logic                err_acc;
  logic [8:0]          burst_len;
  logic [8:0]          rd_left;
  logic [8:0]          beat_cnt;

  logic [DATA_W-1:0]   fifo_mem [2];
  logic                fifo_wp, fifo_rp;
  logic [1:0]          fifo_cnt;
  logic                rd_pend;

  logic                req_hs, aw_hs, w_hs, b_hs;
  logic                push, pop, final_beat;
  logic [DATA_W-1:0]   head;
  logic [BYTES-1:0]    strb_last_eff;
  logic [CW-1:0]       rem_c, max_c, page_c, len_c;
  logic [8:0]          len_now;
  logic                unused_len_hi;

  // Burst length: the smallest of what is left, the burst cap and the beats to the 4 KB page end.
  always_comb begin
    rem_c  = CW'(remaining);
    max_c  = CW'(MAX_BEATS);
    page_c = CW'(13'd4096 - {1'b0, cur_addr[11:0]}) >> BSH;
    len_c  = (rem_c < max_c) ? rem_c : max_c;
    if (page_c < len_c) len_c = page_c;
  end

  assign len_now       = len_c[8:0];
  assign unused_len_hi = ^len_c[CW-1:9];

  assign req_ready   = (state == IDLE);
  assign busy        = !req_ready;
  assign req_hs      = req_valid && req_ready;

  assign axi_awvalid = (state == AW);
  assign axi_awaddr  = axi_awvalid ? cur_addr : '0;
  assign axi_awlen   = axi_awvalid ? 8'(len_now - 9'd1) : '0;
  assign axi_awsize  = 3'(BSH);
  assign axi_awburst = 2'b01;
  assign aw_hs       = axi_awvalid && axi_awready;

  // The beat being read this cycle is presented straight from ur_rdata when the
  // FIFO is empty, so data reaches W one cycle after the read and never waits a slot.
  assign head          = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : ur_rdata;
  assign axi_wvalid    = (state == W) && ((fifo_cnt != 2'd0) || rd_pend);
  assign axi_wdata     = axi_wvalid ? head : '0;
  assign final_beat    = (LEN_W'(beat_cnt) == remaining - LEN_W'(1));
  assign strb_last_eff = (last_strb == '0) ? '1 : last_strb;
  assign axi_wstrb     = axi_wvalid ? (final_beat ? strb_last_eff : '1) : '0;
  assign axi_wlast     = axi_wvalid && (beat_cnt == burst_len - 9'd1);
  assign w_hs          = axi_wvalid && axi_wready;

  assign axi_bready  = (state == B);
  assign b_hs        = axi_bvalid && axi_bready;

  assign ur_re   = (state == W) && (rd_left != 9'd0) && ((fifo_cnt + 2'(rd_pend)) < 2'd2);
  assign ur_addr = ur_ptr;

  assign push = rd_pend && !((fifo_cnt == 2'd0) && w_hs);
  assign pop  = w_hs && (fifo_cnt != 2'd0);

  assign done = (state == FIN);
  assign err  = done && err_acc;

  always_comb begin
    // NOTE: default assigned first so every path drives state_nx; no latch can be inferred.
    state_nx = state;
    case (state)
      IDLE: if (req_hs) state_nx = (req_beats == '0) ? FIN : AW;
      AW:   if (aw_hs) state_nx = W;
      W:    if (w_hs && axi_wlast) state_nx = B;
      B:    if (b_hs) state_nx = (remaining == LEN_W'(burst_len)) ? FIN : AW;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      ur_ptr    <= '0;
      remaining <= '0;
      last_strb <= '0;
      err_acc   <= 1'b0;
      burst_len <= '0;
      rd_left   <= '0;
      beat_cnt  <= '0;
      fifo_wp   <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_cnt  <= '0;
      rd_pend   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register here sees pre-edge values.
      state   <= state_nx;
      rd_pend <= ur_re;

      if (req_hs) begin
        cur_addr  <= req_addr & ~ADDR_W'(BYTES - 1);
        ur_ptr    <= req_ur_base;
        remaining <= req_beats;
        last_strb <= req_last_strb;
        err_acc   <= 1'b0;
      end

      if (aw_hs) begin
        burst_len <= len_now;
        rd_left   <= len_now;
        beat_cnt  <= '0;
      end

      if (ur_re) begin
        rd_left <= rd_left - 9'd1;
        ur_ptr  <= ur_ptr + UR_AW'(1);
      end

      if (w_hs) beat_cnt <= beat_cnt + 9'd1;

      if (push) fifo_wp <= ~fifo_wp;
      if (pop)  fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);

      if (b_hs) begin
        err_acc   <= err_acc | (axi_bresp != 2'b00);
        cur_addr  <= cur_addr + (ADDR_W'(burst_len) << BSH);
        remaining <= remaining - LEN_W'(burst_len);
      end
    end
  end

  // NOTE: FIFO storage has no reset; wdata is masked by wvalid so stale entries never escape.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= ur_rdata;
  end

endmodule

// File: tb/tb_axi_burst_stb.sv
// Bench for axi_burst_stb: a request-level model predicts bursts, beats and UR
// addresses; one compare process checks every handshake against it.
module tb_axi_burst_stb;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int UR_AW     = 12;
  localparam int LEN_W     = 16;
  localparam int MAX_BEATS = 16;
  localparam int BYTES     = DATA_W / 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                req_valid, req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [UR_AW-1:0]    req_ur_base;
  logic [LEN_W-1:0]    req_beats;
  logic [BYTES-1:0]    req_last_strb;
  logic                axi_awvalid, axi_awready;
  logic [ADDR_W-1:0]   axi_awaddr;
  logic [7:0]          axi_awlen;
  logic [2:0]          axi_awsize;
  logic [1:0]          axi_awburst;
  logic                axi_wvalid, axi_wready, axi_wlast;
  logic [DATA_W-1:0]   axi_wdata;
  logic [BYTES-1:0]    axi_wstrb;
  logic                axi_bvalid, axi_bready;
  logic [1:0]          axi_bresp;
  logic                ur_re;
  logic [UR_AW-1:0]    ur_addr;
  logic [DATA_W-1:0]   ur_rdata;
  logic                busy, done, err;

  always #5 clk = ~clk;

  axi_burst_stb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .UR_AW(UR_AW), .LEN_W(LEN_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_ur_base(req_ur_base), .req_beats(req_beats), .req_last_strb(req_last_strb),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .ur_re(ur_re), .ur_addr(ur_addr), .ur_rdata(ur_rdata),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [127:0] data; logic [15:0] strb; logic last; } w_t;

  aw_t          exp_aw[$], obs_aw[$];
  w_t           exp_w[$];
  logic [11:0]  exp_ur[$], obs_ur[$];
  logic [15:0]  obs_strb[$];
  bit           exp_err, obs_err;
  int           err_burst = -1;
  int           b_idx = 0;
  int           done_cnt = 0;
  bit           stall_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] ur_val(input logic [11:0] a);
    return {4{a[7:0] ^ 8'h5A, a, 12'hABC}};
  endfunction

  function automatic aw_t obs_aw_at(input int i);
    return (i < obs_aw.size()) ? obs_aw[i] : '1;
  endfunction

  function automatic logic [15:0] obs_strb_at(input int i);
    return (i < obs_strb.size()) ? obs_strb[i] : 16'hDEAD;
  endfunction

  function automatic logic [11:0] obs_ur_at(input int i);
    return (i < obs_ur.size()) ? obs_ur[i] : 12'hBAD;
  endfunction

  // Request-level model: walk the byte range page by page.
  task automatic build_model(input logic [31:0] addr, input logic [11:0] base,
                             input int beats, input logic [15:0] strb);
    logic [31:0] a;
    logic [11:0] u;
    int rem, room, len, idx, nb;
    aw_t e_aw;
    w_t  e_w;
    a = addr & ~32'(BYTES - 1);
    u = base; rem = beats; idx = 0; nb = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / BYTES;
      len = rem;
      if (len > MAX_BEATS) len = MAX_BEATS;
      if (len > room) len = room;
      e_aw.addr = a;
      e_aw.len  = 8'(len - 1);
      exp_aw.push_back(e_aw);
      for (int i = 0; i < len; i++) begin
        e_w.data = ur_val(u);
        e_w.strb = (idx == beats - 1) ? ((strb == 16'h0) ? 16'hFFFF : strb) : 16'hFFFF;
        e_w.last = (i == len - 1);
        exp_w.push_back(e_w);
        exp_ur.push_back(u);
        u = u + 12'd1;
        idx++;
      end
      a = a + 32'(len * BYTES);
      rem -= len;
      nb++;
    end
    exp_err = (err_burst >= 0) && (err_burst < nb);
  endtask

  // UR file: data appears the cycle after the read enable.
  initial begin : ur_model
    bit re;
    logic [11:0] a;
    ur_rdata = '0;
    forever begin
      @(negedge clk); #1;
      re = ur_re; a = ur_addr;
      @(posedge clk); #1;
      ur_rdata = re ? ur_val(a) : {4{$urandom()}};
    end
  end

  // AXI slave: ready stalls on demand; bvalid outside B is a bait with an error code.
  initial begin : axi_slave
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      axi_awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi_bready) begin
        axi_bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      end else begin
        axi_bvalid = 1'($urandom_range(0, 1));
        axi_bresp  = 2'b11;
      end
    end
  end

  initial begin : compare
    aw_t got_aw, paw, e_aw;
    w_t  got_w, pw, e_w;
    logic [11:0] e_ur;
    bit paw_v, pw_v, have, acc_zero;
    int cyc, ahead, t_acc, t_ur, t_wv, t_br, t_nx, t_rdy;
    cyc = 0; ahead = 0; paw_v = 0; pw_v = 0; acc_zero = 0;
    t_acc = -1; t_ur = -1; t_wv = -1; t_br = -1; t_nx = -1; t_rdy = -1;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (!reset_n) begin
        exp_aw.delete(); exp_w.delete(); exp_ur.delete();
        ahead = 0; paw_v = 0; pw_v = 0;
        t_acc = -1; t_ur = -1; t_wv = -1; t_br = -1; t_nx = -1; t_rdy = -1;
        continue;
      end

      if (cyc == t_acc) check("accept_to_aw_or_done", {axi_awvalid, done}, acc_zero ? 2'b01 : 2'b10);
      if (cyc == t_ur)  check("aw_to_first_ur_re", ur_re, 1'b1);
      if (cyc == t_wv)  check("aw_to_first_wvalid", axi_wvalid, 1'b1);
      if (cyc == t_br)  check("wlast_to_bready", axi_bready, 1'b1);
      if (cyc == t_nx)  check("b_to_next", {axi_awvalid, done}, (exp_aw.size() != 0) ? 2'b10 : 2'b01);
      if (cyc == t_rdy) check("done_to_ready", {req_ready, done}, 2'b10);

      if (req_valid && req_ready) begin
        t_acc = cyc + 1;
        acc_zero = (req_beats == '0);
      end

      got_aw.addr = axi_awaddr;
      got_aw.len  = axi_awlen;
      if (paw_v) check("aw_hold", {axi_awvalid, got_aw}, {1'b1, paw});
      if (axi_awvalid) begin
        check("aw_w_overlap", axi_wvalid, 1'b0);
        if (axi_awready) begin
          have = (exp_aw.size() != 0);
          check("aw_expected", have, 1'b1);
          if (have) begin
            e_aw = exp_aw.pop_front();
            check("aw_addr_len", got_aw, e_aw);
          end
          check("aw_size_burst", {axi_awsize, axi_awburst}, {3'd4, 2'b01});
          obs_aw.push_back(got_aw);
          t_ur = cyc + 1;
          t_wv = cyc + 2;
        end
      end
      paw_v = axi_awvalid && !axi_awready;
      paw   = got_aw;

      if (ur_re) begin
        ahead++;
        check("reads_ahead_le2", ahead <= 2, 1'b1);
        have = (exp_ur.size() != 0);
        check("ur_expected", have, 1'b1);
        if (have) begin
          e_ur = exp_ur.pop_front();
          check("ur_addr", ur_addr, e_ur);
        end
        obs_ur.push_back(ur_addr);
      end

      got_w.data = axi_wdata;
      got_w.strb = axi_wstrb;
      got_w.last = axi_wlast;
      if (pw_v) check("w_hold", {axi_wvalid, got_w}, {1'b1, pw});
      if (axi_wvalid && axi_wready) begin
        ahead--;
        have = (exp_w.size() != 0);
        check("w_expected", have, 1'b1);
        if (have) begin
          e_w = exp_w.pop_front();
          check("wdata", axi_wdata, e_w.data);
          check("wstrb", axi_wstrb, e_w.strb);
          check("wlast", axi_wlast, e_w.last);
        end
        obs_strb.push_back(axi_wstrb);
        if (axi_wlast) t_br = cyc + 1;
      end
      pw_v = axi_wvalid && !axi_wready;
      pw   = got_w;

      if (axi_bready && axi_bvalid) begin
        b_idx++;
        t_nx = cyc + 1;
      end

      if (done) begin
        check("done_err", err, exp_err);
        check("beats_left_at_done", exp_w.size(), 0);
        obs_err = err;
        done_cnt++;
        t_rdy = cyc + 1;
      end
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_ctl"}, {req_ready, busy, done, err, axi_awvalid, axi_wvalid,
                          axi_wlast, axi_bready, ur_re}, 9'b1_0000_0000);
    check({pfx, "_aw"}, {axi_awaddr, axi_awlen}, 40'h0);
    check({pfx, "_w"}, {axi_wdata, axi_wstrb}, 144'h0);
    check({pfx, "_ur_addr"}, ur_addr, 12'h0);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [11:0] base,
                           input int beats, input logic [15:0] strb);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_ur_base = base;
    req_beats = 16'(beats); req_last_strb = strb;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [11:0] base, input int beats,
                        input logic [15:0] strb, input int errb, input bit stall);
    int target;
    obs_aw.delete(); obs_ur.delete(); obs_strb.delete();
    err_burst = errb; stall_en = stall; b_idx = 0;
    build_model(addr, base, beats, strb);
    target = done_cnt + 1;
    drive_req(addr, base, beats, strb);
    for (int i = 0; i < 3000 && done_cnt < target; i++) begin
      @(negedge clk); #2;
    end
    check("done_count", done_cnt, target);
    exp_aw.delete(); exp_w.delete(); exp_ur.delete();
    stall_en = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int saved;
    req_valid = 1'b0; req_addr = '0; req_ur_base = '0; req_beats = '0; req_last_strb = '0;
    reset_n = 1'b0;
    #1;
    check_reset("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // single burst
    do_req(32'h100, 12'h010, 4, 16'h0, -1, 0);
    check("t1_nbursts", obs_aw.size(), 1);
    check("t1_aw0", obs_aw_at(0), {32'h100, 8'd3});
    check("t1_err", obs_err, 1'b0);

    // 4 KB split
    do_req(32'h0FC0, 12'h020, 8, 16'h0, -1, 0);
    check("t2_nbursts", obs_aw.size(), 2);
    check("t2_aw0", obs_aw_at(0), {32'h0FC0, 8'd3});
    check("t2_aw1", obs_aw_at(1), {32'h1000, 8'd3});

    // MAX_BEATS split, final strobe
    do_req(32'h0, 12'h100, 40, 16'h00FF, -1, 0);
    check("t3_aw0", obs_aw_at(0), {32'h000, 8'd15});
    check("t3_aw1", obs_aw_at(1), {32'h100, 8'd15});
    check("t3_aw2", obs_aw_at(2), {32'h200, 8'd7});
    check("t3_strb39", obs_strb_at(39), 16'h00FF);
    check("t3_strb38", obs_strb_at(38), 16'hFFFF);

    // random stalls
    do_req(32'h2000, 12'h300, 20, 16'h0, -1, 1);
    check("t4_nbeats", obs_strb.size(), 20);
    check("t4_aw1", obs_aw_at(1), {32'h2100, 8'd3});

    // error on burst 2 of 3
    do_req(32'h3000, 12'h400, 40, 16'h0, 1, 0);
    check("t5_nbursts", obs_aw.size(), 3);
    check("t5_err", obs_err, 1'b1);

    // clean request after error; unaligned address
    do_req(32'h4008, 12'h500, 5, 16'h0, -1, 0);
    check("t6_aw0", obs_aw_at(0), {32'h4000, 8'd4});
    check("t6_err", obs_err, 1'b0);

    // UR address wrap
    do_req(32'h5000, 12'hFFE, 4, 16'h0, -1, 0);
    check("t7_ur0", obs_ur_at(0), 12'hFFE);
    check("t7_ur1", obs_ur_at(1), 12'hFFF);
    check("t7_ur2", obs_ur_at(2), 12'h000);
    check("t7_ur3", obs_ur_at(3), 12'h001);

    // one beat to the page end
    do_req(32'h1FF0, 12'h050, 3, 16'h0, -1, 0);
    check("t8_aw0", obs_aw_at(0), {32'h1FF0, 8'd0});
    check("t8_aw1", obs_aw_at(1), {32'h2000, 8'd1});

    // zero-beat request
    do_req(32'h6000, 12'h060, 0, 16'h0, -1, 0);
    check("t9_nbursts", obs_aw.size(), 0);
    check("t9_nreads", obs_ur.size(), 0);
    check("t9_err", obs_err, 1'b0);

    // reset during W
    obs_aw.delete(); obs_ur.delete(); obs_strb.delete();
    err_burst = -1; stall_en = 1'b1; b_idx = 0;
    build_model(32'h7000, 12'h040, 20, 16'h0);
    drive_req(32'h7000, 12'h040, 20, 16'h0);
    for (int i = 0; i < 200 && !axi_wvalid; i++) @(negedge clk);
    check("t10_reached_w", axi_wvalid, 1'b1);
    saved = done_cnt;
    reset_n = 1'b0;
    #1;
    check_reset("t10_mid_w");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stall_en = 1'b0;
    check("t10_no_done", done_cnt, saved);

    // normal request after reset
    do_req(32'h8000, 12'h020, 6, 16'h0F0F, -1, 1);
    check("t11_nbursts", obs_aw.size(), 1);
    check("t11_nbeats", obs_strb.size(), 6);
    check("t11_last_strb", obs_strb_at(5), 16'h0F0F);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
